// File: rtl/gate_preact_sequencer_pkg.sv
// Shared definitions for the gate pre-activation sequencer: fixed-point defaults,
// weight-bank select codes and FSM state encoding.
package gate_preact_sequencer_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_FRACT_WIDTH = 5;

  typedef enum logic [1:0] {
    SEL_W0   = 2'd0,
    SEL_W1   = 2'd1,
    SEL_B    = 2'd2,
    SEL_NONE = 2'd3
  } wr_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/gate_mac_stage.sv
// Combinational gate pre-activation: (x*w0)>>>F + (h*w1)>>>F + b, wrapping at DATA_WIDTH.
module gate_mac_stage #(
  parameter int DATA_WIDTH  = 8,
  parameter int FRACT_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] h,
  input  logic [DATA_WIDTH-1:0] w0,
  input  logic [DATA_WIDTH-1:0] w1,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] pre
);

  logic signed [2*DATA_WIDTH-1:0] m0, m1;
  logic        [DATA_WIDTH-1:0]   p0, p1;

  assign m0 = $signed(x) * $signed(w0);
  assign m1 = $signed(h) * $signed(w1);

  // Arithmetic shift floors toward -inf; only the low DATA_WIDTH bits survive.
  assign p0 = DATA_WIDTH'(m0 >>> FRACT_WIDTH);
  assign p1 = DATA_WIDTH'(m1 >>> FRACT_WIDTH);

  assign pre = p0 + p1 + b;

endmodule

// File: rtl/gate_preact_sequencer.sv
// Captures one (x, h) sample and streams W0*x + W1*h + b for every gate in order
// over a valid/ready interface; owns the weight bank, capture and output registers.
module gate_preact_sequencer
  import gate_preact_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
  parameter int N_GATES     = 4,
  parameter int GATE_IDX_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [GATE_IDX_W-1:0] wr_gate,
  input  logic [1:0]            wr_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_h,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [GATE_IDX_W-1:0] out_gate,
  output logic                  out_last
);

  state_e state, state_nx;

  logic [DATA_WIDTH-1:0] w0_bank [N_GATES];
  logic [DATA_WIDTH-1:0] w1_bank [N_GATES];
  logic [DATA_WIDTH-1:0] b_bank  [N_GATES];

  logic [DATA_WIDTH-1:0] x_q, h_q;
  logic [DATA_WIDTH-1:0] mac_x, mac_h, mac_w0, mac_w1, mac_b, pre;
  logic [GATE_IDX_W-1:0] rd_gate;
  logic                  rd_ok;
  logic                  in_ready_c, accept, advance, finish;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            finish   = 1'b1;
            state_nx = IDLE;
          end else begin
            advance  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = in_ready_c & ~rst;

  // In IDLE the MAC works on the live inputs so gate 0 registers on the accept edge.
  assign rd_gate = (state == IDLE) ? '0 : GATE_IDX_W'(out_gate + 1'b1);
  assign rd_ok   = 32'(rd_gate) < N_GATES;
  assign mac_x   = (state == IDLE) ? in_x : x_q;
  assign mac_h   = (state == IDLE) ? in_h : h_q;
  assign mac_w0  = rd_ok ? w0_bank[rd_gate] : '0;
  assign mac_w1  = rd_ok ? w1_bank[rd_gate] : '0;
  assign mac_b   = rd_ok ? b_bank[rd_gate]  : '0;

  gate_mac_stage #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_mac (
    .x   (mac_x),
    .h   (mac_h),
    .w0  (mac_w0),
    .w1  (mac_w1),
    .b   (mac_b),
    .pre (pre)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_gate  <= '0;
      out_last  <= 1'b0;
      x_q       <= '0;
      h_q       <= '0;
    end else if (accept) begin
      x_q       <= in_x;
      h_q       <= in_h;
      out_valid <= 1'b1;
      out_data  <= pre;
      out_gate  <= '0;
      out_last  <= (N_GATES == 1);
    end else if (advance) begin
      out_data  <= pre;
      out_gate  <= rd_gate;
      out_last  <= (32'(rd_gate) == N_GATES - 1);
    end else if (finish) begin
      out_valid <= 1'b0;
    end
  end

  // Bank reads above see the pre-write contents on a colliding edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned g = 0; g < N_GATES; g++) begin
        w0_bank[g] <= '0;
        w1_bank[g] <= '0;
        b_bank[g]  <= '0;
      end
    end else if (wr_en && (32'(wr_gate) < N_GATES)) begin
      case (wr_sel_e'(wr_sel))
        SEL_W0:  w0_bank[wr_gate] <= wr_data;
        SEL_W1:  w1_bank[wr_gate] <= wr_data;
        SEL_B:   b_bank[wr_gate]  <= wr_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_preact_sequencer.sv
// Bench for gate_preact_sequencer: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the sequencer.
module tb_gate_preact_sequencer;

  localparam int NG = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_gate;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x, in_h;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_gate;
  logic       out_last;

  gate_preact_sequencer #(
    .DATA_WIDTH  (8),
    .FRACT_WIDTH (5),
    .N_GATES     (NG),
    .GATE_IDX_W  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_gate   (wr_gate),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_h      (in_h),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_gate  (out_gate),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int         mw0 [NG];
  int         mw1 [NG];
  int         mb  [NG];
  bit         m_busy = 1'b0;
  bit         m_init = 1'b0;
  int         m_gate = 0;
  logic [7:0] m_x, m_h, m_data;

  function automatic logic [7:0] mpre(input int g, input logic [7:0] x, input logic [7:0] h);
    int sx, sh, p0, p1, sum;
    sx  = $signed(x);
    sh  = $signed(h);
    p0  = (sx * mw0[g]) >>> 5;
    p1  = (sh * mw1[g]) >>> 5;
    sum = p0 + p1 + mb[g];
    return 8'(sum);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < NG; g++) begin
        mw0[g] = 0; mw1[g] = 0; mb[g] = 0;
      end
      m_busy = 1'b0;
      m_gate = 0;
      m_init = 1'b1;
    end else begin
      if (!m_busy) begin
        if (in_valid) begin
          m_x    = in_x;
          m_h    = in_h;
          m_gate = 0;
          m_data = mpre(0, in_x, in_h);
          m_busy = 1'b1;
        end
      end else if (out_ready) begin
        if (m_gate == NG - 1) m_busy = 1'b0;
        else begin
          m_gate = m_gate + 1;
          m_data = mpre(m_gate, m_x, m_h);
        end
      end
      if (wr_en && int'(wr_gate) < NG) begin
        case (wr_sel)
          2'd0: mw0[wr_gate] = $signed(wr_data);
          2'd1: mw1[wr_gate] = $signed(wr_data);
          2'd2: mb[wr_gate]  = $signed(wr_data);
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", in_ready, (!m_busy && !rst));
      chk("out_valid", out_valid, m_busy);
      if (m_busy) begin
        chk("out_data", out_data, m_data);
        chk("out_gate", out_gate, m_gate);
        chk("out_last", out_last, (m_gate == NG - 1));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] got     [NG];
  int         got_cyc [NG];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int g, input int sel, input logic [7:0] d);
    wr_en = 1'b1; wr_gate = 2'(g); wr_sel = 2'(sel); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic run_sample(input logic [7:0] x, input logic [7:0] h,
                            input int hold_g, input int hold_n,
                            input int wr_at, input int wg, input int ws, input logic [7:0] wd);
    int n, k, held;
    for (int g = 0; g < NG; g++) begin got[g] = 'x; got_cyc[g] = -1; end
    in_x = x; in_h = h; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!m_busy && n < 20) begin step(); n++; end
    if (!m_busy) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    k = 0; held = 0;
    while (m_busy && k < 40) begin
      got[m_gate] = out_data;
      if (got_cyc[m_gate] < 0) got_cyc[m_gate] = k;
      if (m_gate == hold_g && held < hold_n) begin
        out_ready = 1'b0; in_valid = 1'b1; held++;
      end else begin
        out_ready = 1'b1; in_valid = 1'b0;
      end
      if (m_gate == wr_at) begin
        wr_en = 1'b1; wr_gate = 2'(wg); wr_sel = 2'(ws); wr_data = wd;
      end else wr_en = 1'b0;
      step();
      k++;
    end
    wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    if (m_busy) chk("emit_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_gate = '0; wr_sel = '0; wr_data = '0;
    in_valid = 1'b0; in_x = '0; in_h = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_gate", out_gate, 2'd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    step();

    // basic sample
    wr(0, 0, 8'h40); wr(0, 1, 8'h20); wr(0, 2, 8'h08);
    run_sample(8'h20, 8'h10, -1, 0, -1, 0, 0, 8'h00);
    chk("basic_g0", got[0], 8'h58);
    chk("basic_g1", got[1], 8'h00);
    chk("basic_g3", got[3], 8'h00);
    chk("basic_rate", got_cyc[3], 3);
    chk("basic_ready_back", in_ready, 1'b1);

    // sign and truncation on gate 1
    wr(1, 0, 8'h20);
    run_sample(8'hE0, 8'h00, -1, 0, -1, 0, 0, 8'h00);
    chk("sign_neg1", got[1], 8'hE0);
    wr(1, 0, 8'h01);
    run_sample(8'hFF, 8'h00, -1, 0, -1, 0, 0, 8'h00);
    chk("trunc_floor", got[1], 8'hFF);
    run_sample(8'h01, 8'h00, -1, 0, -1, 0, 0, 8'h00);
    chk("trunc_zero", got[1], 8'h00);

    // wrap-around
    wr(1, 0, 8'h40);
    run_sample(8'h60, 8'h00, -1, 0, -1, 0, 0, 8'h00);
    chk("wrap", got[1], 8'hC0);

    // backpressure on gate 2 with a stray in_valid
    run_sample(8'h33, 8'h44, 2, 5, -1, 0, 0, 8'h00);
    chk("bp_gap", got_cyc[3] - got_cyc[2], 6);

    // write collision on gate 2 bias
    run_sample(8'h10, 8'h10, -1, 0, 1, 2, 2, 8'h10);
    chk("coll_old", got[2], 8'h00);
    run_sample(8'h10, 8'h10, -1, 0, -1, 0, 0, 8'h00);
    chk("coll_new", got[2], 8'h10);
    wr(2, 3, 8'h77);
    run_sample(8'h10, 8'h10, -1, 0, -1, 0, 0, 8'h00);
    chk("sel3_nochange", got[2], 8'h10);

    // reset mid-sample at gate 1
    in_x = 8'h20; in_h = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_gate", out_gate, 2'd1);
    rst = 1'b1;
    step();
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", in_ready, 1'b1);
    run_sample(8'h20, 8'h10, -1, 0, -1, 0, 0, 8'h00);
    chk("cleared_g0", got[0], 8'h00);
    chk("cleared_g2", got[2], 8'h00);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_x      = 8'($urandom);
      in_h      = 8'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      wr_en     = $urandom_range(0, 2) == 0;
      wr_gate   = 2'($urandom);
      wr_sel    = 2'($urandom);
      wr_data   = 8'($urandom);
      step();
    end
    rst = 1'b0; wr_en = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
